// File: rtl/memory_access_arbiter.sv
// Shares one memory tile's write and read ports among NUM_REQ requesters with
// independent round-robin arbiters, write/read collision blocking and fixed-latency read return.

module mem_arb_lane #(
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  valid,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  output logic                  wcand,
  output logic                  rcand,
  output logic                  addr_hit
);
  assign wcand    = valid & we;
  assign rcand    = valid & ~we;
  assign addr_hit = (addr == wr_addr);
endmodule

module memory_access_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]    req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_ready,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [DATA_WIDTH-1:0]            rsp_rdata,
  output logic [ADDR_WIDTH-1:0]            mem_waddr,
  output logic [DATA_WIDTH-1:0]            mem_data_in,
  output logic                             mem_wen,
  output logic [ADDR_WIDTH-1:0]            mem_raddr,
  output logic                             mem_ren,
  input  logic [DATA_WIDTH-1:0]            mem_data_out
);
  localparam int IDW    = $clog2(NUM_REQ);
  localparam int STAGES = 1;

  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] addr_a;
  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] wdata_a;
  logic [NUM_REQ-1:0]                 wcand, rcand, addr_hit;
  logic [IDW-1:0]                     wptr, rptr, wsel, rsel;
  logic                               wfound, rfound, go, collide, wgnt, rgnt;
  logic [STAGES:0]                    vld_pipe;
  logic [STAGES:0][IDW-1:0]           id_pipe;

  assign addr_a  = req_addr;
  assign wdata_a = req_wdata;

  // Each lane compares its address against the selected write so the read
  // winner's collision bit is a simple index.
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    mem_arb_lane #(.ADDR_WIDTH(ADDR_WIDTH)) u_lane (
      .valid    (req_valid[i]),
      .we       (req_we[i]),
      .addr     (addr_a[i]),
      .wr_addr  (addr_a[wsel]),
      .wcand    (wcand[i]),
      .rcand    (rcand[i]),
      .addr_hit (addr_hit[i])
    );
  end

  always_comb begin
    wfound = 1'b0;
    wsel   = '0;
    rfound = 1'b0;
    rsel   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!wfound && wcand[IDW'((int'(wptr) + k) % NUM_REQ)]) begin
        wfound = 1'b1;
        wsel   = IDW'((int'(wptr) + k) % NUM_REQ);
      end
      if (!rfound && rcand[IDW'((int'(rptr) + k) % NUM_REQ)]) begin
        rfound = 1'b1;
        rsel   = IDW'((int'(rptr) + k) % NUM_REQ);
      end
    end
  end

  assign go      = enable & ~reset;
  // The priority read winner is held back rather than passed over, so a
  // same-address read always lands after the write commits.
  assign collide = wfound & rfound & addr_hit[rsel];
  assign wgnt    = go & wfound;
  assign rgnt    = go & rfound & ~collide;

  always_comb begin
    req_ready = '0;
    if (wgnt) req_ready[wsel] = 1'b1;
    if (rgnt) req_ready[rsel] = 1'b1;
  end

  always_comb begin
    rsp_valid = '0;
    if (vld_pipe[STAGES]) rsp_valid[id_pipe[STAGES]] = 1'b1;
  end
  assign rsp_rdata = mem_data_out;

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr        <= '0;
      rptr        <= '0;
      mem_wen     <= 1'b0;
      mem_ren     <= 1'b0;
      mem_waddr   <= '0;
      mem_raddr   <= '0;
      mem_data_in <= '0;
      vld_pipe    <= '0;
      id_pipe     <= '0;
    end else begin
      mem_wen <= wgnt;
      mem_ren <= rgnt;
      if (wgnt) begin
        wptr        <= IDW'((int'(wsel) + 1) % NUM_REQ);
        mem_waddr   <= addr_a[wsel];
        mem_data_in <= wdata_a[wsel];
      end
      if (rgnt) begin
        rptr      <= IDW'((int'(rsel) + 1) % NUM_REQ);
        mem_raddr <= addr_a[rsel];
      end
      vld_pipe <= {vld_pipe[STAGES-1:0], rgnt};
      id_pipe  <= {id_pipe[STAGES-1:0], rsel};
    end
  end
endmodule
